// File: rtl/mem_stage_pkg.sv
// Shared bus widths and load-op encodings for the MEM stage and its neighbours.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 74;
    localparam int MS_FWD_BUS_WD   = 39;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } load_op_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment/extension and WB byte-enable generation (combinational).
import mem_stage_pkg::*;

module mem_load_align (
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr_low,
    input  logic [31:0] rdata,
    input  logic [31:0] alu_result,
    input  logic        gr_we,
    output logic [31:0] final_result,
    output logic [3:0]  byte_we
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [3:0]  we_raw;

    assign sel_b = rdata[{addr_low, 3'b000} +: 8];
    assign sel_h = addr_low[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        final_result = alu_result;
        we_raw       = 4'b1111;
        case (load_op_e'(load_op))
            LD_LB:   final_result = {{24{sel_b[7]}}, sel_b};
            LD_LBU:  final_result = {24'd0, sel_b};
            LD_LH:   final_result = {{16{sel_h[15]}}, sel_h};
            LD_LHU:  final_result = {16'd0, sel_h};
            LD_LW:   final_result = rdata;
            // 3-a == ~a for a 2-bit offset
            LD_LWL: begin
                final_result = rdata << {~addr_low, 3'b000};
                we_raw       = 4'b1111 << ~addr_low;
            end
            LD_LWR: begin
                final_result = rdata >> {addr_low, 3'b000};
                we_raw       = 4'b1111 >> addr_low;
            end
            default: final_result = alu_result;
        endcase
    end

    assign byte_we = gr_we ? we_raw : 4'b0000;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: waits on data-SRAM responses, buffers them under WB backpressure,
// aligns load data. Optional MS_EX_FLUSH_EN adds ws_flush with stale-response discard.
import mem_stage_pkg::*;

module mem_stage (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
`ifdef MS_EX_FLUSH_EN
    input  logic                       ws_flush,
`endif
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
    logic        ms_valid;
    logic        buf_valid;
    logic [31:0] rdata_buf;
    logic        resp_ok;
    logic        ms_ready_go;

    logic        mem_req;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] rdata_eff;
    logic [31:0] final_result;
    logic [3:0]  byte_we;

    assign {mem_req, load_op, gr_we, dest, alu_result, pc} = ms_bus;

`ifdef MS_EX_FLUSH_EN
    logic discard;
    logic flush_wait;

    // A response owed to a flushed instruction must not complete the next one
    assign resp_ok    = data_sram_data_ok && !discard;
    assign flush_wait = ws_flush && ms_valid && mem_req && !buf_valid && !resp_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  discard <= 1'b0;
        else if (flush_wait)        discard <= 1'b1;
        else if (data_sram_data_ok) discard <= 1'b0;
    end
`else
    assign resp_ok = data_sram_data_ok;
`endif

    assign ms_ready_go    = !mem_req || resp_ok || buf_valid;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           ms_valid <= 1'b0;
`ifdef MS_EX_FLUSH_EN
        else if (ws_flush)   ms_valid <= 1'b0;
`endif
        else if (ms_allowin) ms_valid <= es_to_ms_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             ms_bus <= '0;
        else if (es_to_ms_valid && ms_allowin) ms_bus <= es_to_ms_bus;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            rdata_buf <= '0;
        end
`ifdef MS_EX_FLUSH_EN
        else if (ws_flush) buf_valid <= 1'b0;
`endif
        else if (ms_to_ws_valid && ws_allowin) buf_valid <= 1'b0;
        else if (ms_valid && mem_req && resp_ok && !ws_allowin && !buf_valid) begin
            buf_valid <= 1'b1;
            rdata_buf <= data_sram_rdata;
        end
    end

    assign rdata_eff = buf_valid ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .load_op      (load_op),
        .addr_low     (alu_result[1:0]),
        .rdata        (rdata_eff),
        .alu_result   (alu_result),
        .gr_we        (gr_we),
        .final_result (final_result),
        .byte_we      (byte_we)
    );

    assign ms_to_ws_bus = {byte_we, gr_we, dest, final_result, pc};

    assign ms_fwd_bus = ms_valid ? {gr_we && (load_op != 3'd0) && !ms_ready_go,
                                    gr_we, dest, final_result}
                                 : '0;

`ifndef SYNTHESIS
    // one response per instruction: nothing may arrive once it is buffered
    assert property (@(posedge clk) disable iff (reset) !(buf_valid && data_sram_data_ok));
`endif

endmodule
